// File: rtl/sync_2ff.sv
// Two-flop synchronizer that brings an asynchronous level into the clk domain.
// Both stages clear to 0 on a synchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make meta and q sample together on the
  // edge, so q always sees the previous meta and the chain really is two flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/push_button_debouncer.sv
// Push-button debouncer: the synchronized level must differ from the debounced
// state for 2^CNT_WIDTH consecutive cycles before the state flips and a strobe fires.
module push_button_debouncer #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic PB,
  output logic PB_state,
  output logic PB_down,
  output logic PB_up
);

  logic                 sync;
  logic                 idle;
  logic                 cnt_max;
  logic [CNT_WIDTH-1:0] cnt;

  // The button is active-low; invert before synchronizing so sync = 1 means pressed.
  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (~PB),
    .q   (sync)
  );

  assign idle    = (PB_state == sync);
  assign cnt_max = &cnt;

  // Any cycle where sync agrees with PB_state (a bounce back) restarts the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      PB_state <= 1'b0;
    end else if (idle) begin
      cnt <= '0;
    end else begin
      // At all-ones this increment wraps to 0 in the same cycle PB_state flips.
      cnt <= cnt + CNT_WIDTH'(1);
      if (cnt_max) PB_state <= ~PB_state;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    PB_down = 1'b0;
    PB_up   = 1'b0;
    if (!rst && !idle && cnt_max) begin
      PB_down = ~PB_state;
      PB_up   = PB_state;
    end
  end

endmodule

// File: tb/tb_push_button_debouncer.sv
// Self-checking bench for push_button_debouncer with CNT_WIDTH = 4 (16-cycle window).
// A run-length reference model is compared every cycle; directed scenarios check timing.
module tb_push_button_debouncer;

  localparam int W   = 4;
  localparam int WIN = 1 << W;
  localparam int LAT = 2 + WIN;

  logic clk = 1'b0;
  logic rst;
  logic PB;
  logic PB_state;
  logic PB_down;
  logic PB_up;

  int checks = 0;
  int errors = 0;

  // Reference model: registered button samples plus the length of the current
  // run of cycles in which the synchronized level disagrees with the state.
  logic m_s1, m_sync, m_state;
  int   m_run;

  int cyc = 0;
  int n_down, n_up;
  int last_down, last_up, rise_cyc;
  logic prev_state;
  int t0;

  push_button_debouncer #(.CNT_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .PB       (PB),
    .PB_state (PB_state),
    .PB_down  (PB_down),
    .PB_up    (PB_up)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_stats();
    n_down    = 0;
    n_up      = 0;
    last_down = -1;
    last_up   = -1;
    rise_cyc  = -1;
  endtask

  // Advance one clock: update the model on the rising edge, compare on the falling edge.
  task automatic tick();
    logic strobe;
    int   base;
    @(posedge clk);
    cyc++;
    if (rst) begin
      m_s1    = 1'b0;
      m_sync  = 1'b0;
      m_state = 1'b0;
      m_run   = 0;
    end else begin
      strobe = (m_run == WIN);
      if (strobe) m_state = !m_state;
      base   = strobe ? 0 : m_run;
      m_sync = m_s1;
      m_s1   = !PB;
      m_run  = (m_sync != m_state) ? base + 1 : 0;
    end
    @(negedge clk);
    check("pb_state", PB_state, m_state);
    check("pb_down", PB_down, !rst && m_run == WIN && !m_state);
    check("pb_up", PB_up, !rst && m_run == WIN && m_state);
    check("strobe_exclusive", PB_down & PB_up, 1'b0);
    if (PB_down === 1'b1) begin n_down++; last_down = cyc; end
    if (PB_up === 1'b1)   begin n_up++;   last_up   = cyc; end
    if (PB_state === 1'b1 && prev_state === 1'b0) rise_cyc = cyc;
    prev_state = PB_state;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    m_s1 = 1'b0; m_sync = 1'b0; m_state = 1'b0; m_run = 0;
    prev_state = 1'b0;
    clear_stats();

    // Reset held 3 cycles with the button pressed.
    rst = 1'b1;
    PB  = 1'b0;
    ticks(3);
    check("reset_state", PB_state, 1'b0);
    check("reset_no_strobe", n_down + n_up, 0);
    // The cycle in which rst falls counts as the first of the LAT cycles.
    t0  = cyc;
    rst = 1'b0;
    ticks(30);
    check("reset_release_downs", n_down, 1);
    check("reset_release_latency", last_down - t0 + 1, LAT);

    // Clean release.
    clear_stats();
    t0 = cyc;
    PB = 1'b1;
    ticks(30);
    check("release_ups", n_up, 1);
    check("release_latency", last_up - t0 + 1, LAT);
    check("release_downs", n_down, 0);
    check("release_state", PB_state, 1'b0);

    // Clean press.
    clear_stats();
    t0 = cyc;
    PB = 1'b0;
    ticks(30);
    check("press_downs", n_down, 1);
    check("press_latency", last_down - t0 + 1, LAT);
    check("press_state_next", rise_cyc, last_down + 1);
    check("press_ups", n_up, 0);
    check("press_state", PB_state, 1'b1);

    PB = 1'b1;
    ticks(30);

    // Bounce: toggle every 5 cycles for 60 cycles, then settle pressed.
    clear_stats();
    for (int i = 0; i < 12; i++) begin
      PB = ~PB;
      ticks(5);
    end
    check("bounce_no_strobe", n_down + n_up, 0);
    check("bounce_state", PB_state, 1'b0);
    t0 = cyc;
    PB = 1'b0;
    ticks(30);
    check("bounce_downs", n_down, 1);
    check("bounce_latency", last_down - t0 + 1, LAT);

    PB = 1'b1;
    ticks(30);

    // Long hold must strobe once only.
    clear_stats();
    PB = 1'b0;
    ticks(200);
    check("hold_downs", n_down, 1);
    check("hold_ups", n_up, 0);
    check("hold_state", PB_state, 1'b1);

    PB = 1'b1;
    ticks(30);

    // Reset 10 cycles into a press window abandons the count.
    clear_stats();
    PB = 1'b0;
    ticks(10);
    rst = 1'b1;
    ticks(2);
    check("midreset_no_strobe", n_down + n_up, 0);
    check("midreset_state", PB_state, 1'b0);
    t0  = cyc;
    rst = 1'b0;
    ticks(30);
    check("midreset_downs", n_down, 1);
    check("midreset_latency", last_down - t0 + 1, LAT);

    // Randomized button activity against the model, including short resets.
    for (int i = 0; i < 60; i++) begin
      PB  = 1'($urandom_range(0, 1));
      rst = ($urandom_range(0, 19) == 0);
      ticks($urandom_range(1, 25));
      rst = 1'b0;
    end
    ticks(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
